mux_2_to_1: RTL and testbench
=============================

# mux_2_to_1

Parameterised 2-to-1 data multiplexer used throughout the RV64F datapath wherever one of two equal-width operands is steered onto a bus (e.g. ALU operand selection, writeback source). It provides a purely combinational selected output and, alongside it, an optional-use registered copy of the selection with a load enable and valid flag. The registered copy is for pipeline boundaries that need the selected value held.

## Interface
- `Size`, default 64: width in bits of `i0`, `i1`, `data_o`, `data_q`; legal range 1..1024.

- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `sel` input, 1: select; 0 picks `i0`, 1 picks `i1`.
- `i0` input, `Size`: data input 0.
- `i1` input, `Size`: data input 1.
- `en` input, 1: load enable for the registered stage.
- `data_o` output, `Size`: combinational selected data.
- `data_q` output, `Size`: registered selected data.
- `sel_q` output, 1: `sel` value captured with `data_q`.
- `valid_q` output, 1: one-cycle pulse, high the cycle after a load.
- `parity_q` output, 1: present only with `MUX_2_TO_1_PARITY_EN`; even parity (XOR reduction) of `data_q`.

## Operation
- `data_o = sel ? i1 : i0`, bit-for-bit, all `Size` bits, no truncation or extension.
- `data_o` is purely combinational:
  - no dependence on `clk`, `rst` or `en`;
  - valid during reset.
- Rising edge of `clk`, in priority order:
  - `rst`=1: `data_q`<=0, `sel_q`<=0, `valid_q`<=0 (and `parity_q`<=0); `en` ignored.
  - `en`=1: `data_q`<=`data_o`, `sel_q`<=`sel`, `valid_q`<=1.
  - `en`=0: `data_q` and `sel_q` hold; `valid_q`<=0.
- `parity_q` is registered together with `data_q`, always equal to `^data_q`.
- `i0`==`i1`: `data_o` equals that value regardless of `sel`.
- `Size`=1 is legal: the block degenerates to a 1-bit mux with the same behaviour.
- No internal state other than `data_q`, `sel_q`, `valid_q` and `parity_q`.

## Timing
- `data_o` latency: 0 cycles, combinational path from `sel`, `i0`, `i1`. Must settle within one simulation time step of an input change.
- `data_q`/`sel_q`/`valid_q` latency: 1 cycle after an edge with `en`=1.
- Back-to-back `en` keeps `valid_q` high continuously, with new data each cycle.
- Reset values: `data_q`=0, `sel_q`=0, `valid_q`=0, `parity_q`=0. `data_o` has no reset value; it tracks its inputs.
- Reset asserted mid-stream clears registered outputs on the next edge, even if `en`=1 that cycle.
- First load after reset deassertion is accepted on the first edge where `rst`=0 and `en`=1.

## Configuration
- `MUX_2_TO_1_PARITY_EN` defined:
  - `parity_q` port and its flop exist;
  - `parity_q` resets to 0;
  - otherwise `parity_q` tracks `^data_q`.
- Not defined:
  - no `parity_q` port and no parity logic;
  - all other behaviour identical.

## Test plan
- Comb select 0: `i0`=64'h0123_4567_89AB_CDEF, `i1`=64'hFEDC_BA98_7654_3210, `sel`=0 -> after #1, `data_o`=64'h0123_4567_89AB_CDEF.
- Comb select 1: same data, `sel`=1 -> after #1, `data_o`=64'hFEDC_BA98_7654_3210. Repeat with random `{$urandom,$urandom}` pairs; the error count must be 0.
- Reset: `rst`=1, `en`=1 for one edge -> `data_q`=0, `sel_q`=0, `valid_q`=0. `data_o` still follows `sel` during reset.
- Load: `rst`=0, `en`=1, `sel`=1, `i1`=64'hDEAD_BEEF_0000_0001 -> next cycle `data_q`=64'hDEAD_BEEF_0000_0001, `sel_q`=1, `valid_q`=1. Then `en`=0 -> `data_q` holds, `valid_q`=0.
- Parity (macro defined): load `data_q`=64'h0000_0000_0000_0007 -> `parity_q`=1. Load 64'h3 -> `parity_q`=0.
- `Size`=1: `i0`=0, `i1`=1 -> `data_o`=`sel` for both values of `sel`.

Source files
------------

// File: rtl/mux_2_to_1.sv
// rtl/mux_2_to_1.sv - 2-to-1 data mux with combinational output and an enabled registered copy
// Optional parity flop on the registered copy: define MUX_2_TO_1_PARITY_EN.
module mux_2_to_1 #(
    parameter int Size = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic [Size-1:0] i0,
    input  logic [Size-1:0] i1,
    input  logic            en,
    output logic [Size-1:0] data_o,
    output logic [Size-1:0] data_q,
    output logic            sel_q,
    output logic            valid_q
`ifdef MUX_2_TO_1_PARITY_EN
    ,
    output logic            parity_q
`endif
);

    always_comb begin
        data_o = sel ? i1 : i0;
    end

    // valid_q is a pulse: it drops on any edge without a load, while data/sel hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            data_q  <= data_o;
            sel_q   <= sel;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

`ifdef MUX_2_TO_1_PARITY_EN
    // Computed from data_o at load time so it always matches ^data_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (en) begin
            parity_q <= ^data_o;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2_to_1.sv
// tb/tb_mux_2_to_1.sv - randomized self-checking bench for mux_2_to_1 (Size=64 and Size=1)
module tb_mux_2_to_1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, en;
    logic [63:0] i0, i1;
    logic [63:0] data_o, data_q;
    logic        sel_q, valid_q;

    logic        rst1, sel1, en1;
    logic [0:0]  a0, a1;
    logic [0:0]  d1_o, d1_q;
    logic        s1_q, v1_q;

`ifdef MUX_2_TO_1_PARITY_EN
    logic        parity_q, parity1_q;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] m_data;
    logic        m_sel, m_valid;
    logic [0:0]  m1_data;

    mux_2_to_1 #(.Size(64)) dut (
        .clk(clk), .rst(rst), .sel(sel), .i0(i0), .i1(i1), .en(en),
        .data_o(data_o), .data_q(data_q), .sel_q(sel_q), .valid_q(valid_q)
`ifdef MUX_2_TO_1_PARITY_EN
        , .parity_q(parity_q)
`endif
    );

    mux_2_to_1 #(.Size(1)) dut1 (
        .clk(clk), .rst(rst1), .sel(sel1), .i0(a0), .i1(a1), .en(en1),
        .data_o(d1_o), .data_q(d1_q), .sel_q(s1_q), .valid_q(v1_q)
`ifdef MUX_2_TO_1_PARITY_EN
        , .parity_q(parity1_q)
`endif
    );

    function automatic logic [63:0] pick(input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] v [2];
        v[0] = a;
        v[1] = b;
        return v[s];
    endfunction

    // Advance one clock edge, updating the reference state from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_data  = '0;
            m_sel   = 1'b0;
            m_valid = 1'b0;
        end else if (en) begin
            m_data  = pick(sel, i0, i1);
            m_sel   = sel;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (rst1) m1_data = 1'b0;
        else if (en1) m1_data = sel1 ? a1 : a0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sel = 1'b1;
        i0 = {$urandom, $urandom}; i1 = {$urandom, $urandom};
        tick();
        checks++; if (data_q !== 64'd0) begin errors++; $display("FAIL reset_data_q got %h want 0", data_q); end
        checks++; if (sel_q !== 1'b0) begin errors++; $display("FAIL reset_sel_q got %b want 0", sel_q); end
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid_q got %b want 0", valid_q); end
        checks++; if (data_o !== i1) begin errors++; $display("FAIL reset_data_o got %h want %h", data_o, i1); end
`ifdef MUX_2_TO_1_PARITY_EN
        checks++; if (parity_q !== 1'b0) begin errors++; $display("FAIL reset_parity_q got %b want 0", parity_q); end
`endif
    endtask

    task automatic test_comb();
        i0 = 64'h0123_4567_89AB_CDEF; i1 = 64'hFEDC_BA98_7654_3210;
        sel = 1'b0; #1;
        checks++; if (data_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL comb_sel0 got %h want 0123456789abcdef", data_o); end
        sel = 1'b1; #1;
        checks++; if (data_o !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL comb_sel1 got %h want fedcba9876543210", data_o); end
        for (int k = 0; k < 24; k++) begin
            i0 = {$urandom, $urandom}; i1 = {$urandom, $urandom}; sel = 1'($urandom);
            #1;
            checks++;
            if (data_o !== pick(sel, i0, i1)) begin
                errors++; $display("FAIL comb_rand[%0d] got %h want %h", k, data_o, pick(sel, i0, i1));
            end
        end
    endtask

    task automatic test_equal_inputs();
        i0 = {$urandom, $urandom}; i1 = i0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            checks++; if (data_o !== i0) begin errors++; $display("FAIL equal_sel%0d got %h want %h", s, data_o, i0); end
        end
    endtask

    task automatic test_load();
        rst = 1'b0; en = 1'b1; sel = 1'b1;
        i0 = {$urandom, $urandom}; i1 = 64'hDEAD_BEEF_0000_0001;
        tick();
        checks++; if (data_q !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL load_data_q got %h want deadbeef00000001", data_q); end
        checks++; if (sel_q !== 1'b1) begin errors++; $display("FAIL load_sel_q got %b want 1", sel_q); end
        checks++; if (valid_q !== 1'b1) begin errors++; $display("FAIL load_valid_q got %b want 1", valid_q); end
        en = 1'b0; sel = 1'b0; i0 = {$urandom, $urandom}; i1 = {$urandom, $urandom};
        tick();
        checks++; if (data_q !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL hold_data_q got %h want deadbeef00000001", data_q); end
        checks++; if (sel_q !== 1'b1) begin errors++; $display("FAIL hold_sel_q got %b want 1", sel_q); end
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL hold_valid_q got %b want 0", valid_q); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            en = (k < 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
            sel = 1'($urandom); i0 = {$urandom, $urandom}; i1 = {$urandom, $urandom};
            tick();
            checks++;
            if (data_q !== m_data || sel_q !== m_sel || valid_q !== m_valid) begin
                errors++;
                $display("FAIL b2b[%0d] got %h/%b/%b want %h/%b/%b", k, data_q, sel_q, valid_q, m_data, m_sel, m_valid);
            end
`ifdef MUX_2_TO_1_PARITY_EN
            checks++; if (parity_q !== ^m_data) begin errors++; $display("FAIL b2b_parity[%0d] got %b want %b", k, parity_q, ^m_data); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; en = 1'b1; sel = 1'b0; i0 = 64'hFFFF_0000_FFFF_0001; i1 = {$urandom, $urandom};
        tick();
        rst = 1'b1; en = 1'b1; sel = 1'b1;
        tick();
        checks++;
        if (data_q !== 64'd0 || sel_q !== 1'b0 || valid_q !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %h/%b/%b want 0/0/0", data_q, sel_q, valid_q);
        end
        rst = 1'b0; i1 = {$urandom, $urandom};
        tick();
        checks++;
        if (data_q !== i1 || sel_q !== 1'b1 || valid_q !== 1'b1) begin
            errors++; $display("FAIL first_load got %h/%b/%b want %h/1/1", data_q, sel_q, valid_q, i1);
        end
    endtask

`ifdef MUX_2_TO_1_PARITY_EN
    task automatic test_parity();
        rst = 1'b0; en = 1'b1; sel = 1'b0; i0 = 64'h7;
        tick();
        checks++; if (parity_q !== 1'b1) begin errors++; $display("FAIL parity_7 got %b want 1", parity_q); end
        i0 = 64'h3;
        tick();
        checks++; if (parity_q !== 1'b0) begin errors++; $display("FAIL parity_3 got %b want 0", parity_q); end
    endtask
`endif

    task automatic test_size1();
        a0 = 1'b0; a1 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel1 = 1'(s); #1;
            checks++; if (d1_o !== 1'(s)) begin errors++; $display("FAIL size1_comb sel=%0d got %b want %0d", s, d1_o, s); end
        end
        rst1 = 1'b0; en1 = 1'b1; sel1 = 1'b1;
        tick();
        checks++;
        if (d1_q !== m1_data || s1_q !== 1'b1 || v1_q !== 1'b1) begin
            errors++; $display("FAIL size1_load got %b/%b/%b want %b/1/1", d1_q, s1_q, v1_q, m1_data);
        end
        en1 = 1'b0; sel1 = 1'b0;
        tick();
        checks++;
        if (d1_q !== m1_data || v1_q !== 1'b0) begin
            errors++; $display("FAIL size1_hold got %b/%b want %b/0", d1_q, v1_q, m1_data);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b0; i0 = '0; i1 = '0;
        rst1 = 1'b1; en1 = 1'b0; sel1 = 1'b0; a0 = '0; a1 = '0;
        m_data = '0; m_sel = 1'b0; m_valid = 1'b0; m1_data = '0;
        test_reset();
        test_comb();
        test_equal_inputs();
        test_load();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX_2_TO_1_PARITY_EN
        test_parity();
`endif
        test_size1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
